// File: rtl/sonic_tx_arbiter.sv
// Round-robin owner of the single PCIe backend TX port shared by NUM_REQ requesters.
// Grant -> active -> drain sequencing keeps TLPs from different requesters from interleaving.
module sonic_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GRANT_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_busy,
  output logic [NUM_REQ-1:0]       req_sel,
  output logic [NUM_REQ-1:0]       req_ready_others,
  input  logic [NUM_REQ-1:0]       req_tx_req,
  input  logic [NUM_REQ-1:0]       req_tx_dfr,
  input  logic [NUM_REQ-1:0]       req_tx_dv,
  input  logic [NUM_REQ-1:0]       req_tx_err,
  input  logic [NUM_REQ*128-1:0]   req_tx_desc,
  input  logic [NUM_REQ*128-1:0]   req_tx_data,
  output logic [NUM_REQ-1:0]       req_tx_ack,
  output logic [NUM_REQ-1:0]       req_tx_ws,
  output logic                     tx_req,
  output logic                     tx_dfr,
  output logic                     tx_dv,
  output logic                     tx_err,
  output logic [127:0]             tx_desc,
  output logic [127:0]             tx_data,
  input  logic                     tx_ack,
  input  logic                     tx_ws,
  output logic [2:0]               grant_id,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             grant_id_nxt, last_winner, last_winner_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic [NUM_REQ-1:0]     req_sel_nxt, win_oh;
  logic                   timeout_err_nxt, active;
  logic                   busy_w, tx_pending_w;
  logic [3:0]             pick;
  logic [NUM_REQ*128-1:0] desc_sh, data_sh;

  // First ready requester after the last winner, with wrap; bit 3 flags a hit.
  function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] ready,
                                         input logic [2:0]         last);
    logic [3:0] res;
    int         idx;
    res = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!res[3] && ((ready >> idx) & NUM_REQ'(1)) != '0)
        res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

  assign pick         = rr_pick(req_ready, last_winner);
  assign win_oh       = NUM_REQ'(1) << grant_id;
  assign active       = (state != IDLE);
  assign busy_w       = |(req_busy & win_oh);
  assign tx_pending_w = |((req_tx_req | req_tx_dfr | req_tx_dv) & win_oh);

  always_comb begin
    state_nxt       = state;
    grant_id_nxt    = grant_id;
    last_winner_nxt = last_winner;
    cnt_nxt         = cnt;
    req_sel_nxt     = req_sel;
    timeout_err_nxt = timeout_err;
    unique case (state)
      IDLE: begin
        if (pick[3]) begin
          state_nxt    = GRANT;
          grant_id_nxt = pick[2:0];
          cnt_nxt      = '0;
          req_sel_nxt  = NUM_REQ'(1) << pick[2:0];
        end
      end
      GRANT: begin
        if (busy_w) begin
          state_nxt = ACTIVE;
        end else if (cnt == CNT_WIDTH'(GRANT_TIMEOUT - 1)) begin
          // Requester never started: revoke and give the turn away.
          state_nxt       = IDLE;
          req_sel_nxt     = '0;
          timeout_err_nxt = 1'b1;
          last_winner_nxt = grant_id;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (!busy_w) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!tx_pending_w) begin
          state_nxt       = IDLE;
          req_sel_nxt     = '0;
          last_winner_nxt = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state       <= IDLE;
      req_sel     <= '0;
      grant_id    <= '0;
      last_winner <= 3'(NUM_REQ - 1);
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_sel     <= req_sel_nxt;
      grant_id    <= grant_id_nxt;
      last_winner <= last_winner_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  // Backend mux: zero-latency path from the owner, quiet while idle.
  always_comb begin
    desc_sh          = req_tx_desc >> {grant_id, 7'd0};
    data_sh          = req_tx_data >> {grant_id, 7'd0};
    tx_req           = active & |(req_tx_req & win_oh);
    tx_dfr           = active & |(req_tx_dfr & win_oh);
    tx_dv            = active & |(req_tx_dv  & win_oh);
    tx_err           = active & |(req_tx_err & win_oh);
    tx_desc          = active ? desc_sh[127:0] : '0;
    tx_data          = active ? data_sh[127:0] : '0;
    req_ready_others = active ? ~win_oh : '0;
    req_tx_ack       = tx_ack ? req_sel : '0;
    req_tx_ws        = ~req_sel | (tx_ws ? req_sel : '0);
  end

endmodule

// File: tb/tb_sonic_tx_arbiter.sv
// Bench for sonic_tx_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_sonic_tx_arbiter;
  localparam int N = 4;
  localparam int T = 64;

  logic           clk_in = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_ready = '0, req_busy = '0;
  logic [N-1:0]   req_tx_req = '0, req_tx_dfr = '0, req_tx_dv = '0, req_tx_err = '0;
  logic [N*128-1:0] req_tx_desc = '0, req_tx_data = '0;
  logic           tx_ack = 1'b0, tx_ws = 1'b0;
  logic [N-1:0]   req_sel, req_ready_others, req_tx_ack, req_tx_ws;
  logic           tx_req, tx_dfr, tx_dv, tx_err, timeout_err;
  logic [127:0]   tx_desc, tx_data;
  logic [2:0]     grant_id;

  int errors = 0;
  int checks = 0;

  sonic_tx_arbiter #(.NUM_REQ(N), .GRANT_TIMEOUT(T), .CNT_WIDTH(8)) dut (
    .clk_in(clk_in), .reset(reset),
    .req_ready(req_ready), .req_busy(req_busy),
    .req_sel(req_sel), .req_ready_others(req_ready_others),
    .req_tx_req(req_tx_req), .req_tx_dfr(req_tx_dfr), .req_tx_dv(req_tx_dv),
    .req_tx_err(req_tx_err), .req_tx_desc(req_tx_desc), .req_tx_data(req_tx_data),
    .req_tx_ack(req_tx_ack), .req_tx_ws(req_tx_ws),
    .tx_req(tx_req), .tx_dfr(tx_dfr), .tx_dv(tx_dv), .tx_err(tx_err),
    .tx_desc(tx_desc), .tx_data(tx_data), .tx_ack(tx_ack), .tx_ws(tx_ws),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic bitof(input logic [N-1:0] v, input int i);
    return |(v & (N'(1) << i));
  endfunction

  function automatic logic [127:0] slot(input logic [N*128-1:0] v, input int i);
    logic [N*128-1:0] s;
    s = v >> (i * 128);
    return s[127:0];
  endfunction

  function automatic logic [N*128-1:0] rand_wide();
    logic [N*128-1:0] v;
    v = '0;
    for (int k = 0; k < N * 4; k++) v = (v << 32) | (N*128)'($urandom);
    return v;
  endfunction

  function automatic int idx_of(input logic [N-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (oh == (N'(1) << i)) r = i;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the port and how far its transaction has progressed.
  int m_owner = -1, m_gid = 0, m_last = N - 1, m_wait = 0;
  bit m_terr = 0, m_started = 0, m_ended = 0, m_valid = 0;

  always @(posedge clk_in) begin
    if (reset) begin
      m_owner = -1; m_gid = 0; m_last = N - 1; m_wait = 0; m_terr = 0; m_valid = 1;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++)
        if (m_owner < 0 && bitof(req_ready, (m_last + k) % N)) begin
          m_owner = (m_last + k) % N;
          m_gid   = m_owner;
        end
      m_wait = 0; m_started = 0; m_ended = 0;
    end else if (!m_started) begin
      if (bitof(req_busy, m_owner)) m_started = 1;
      else if (m_wait == T - 1) begin m_terr = 1; m_last = m_owner; m_owner = -1; end
      else m_wait++;
    end else if (!m_ended) begin
      if (!bitof(req_busy, m_owner)) m_ended = 1;
    end else if (!bitof(req_tx_req | req_tx_dfr | req_tx_dv, m_owner)) begin
      m_last = m_owner; m_owner = -1;
    end
  end

  always @(negedge clk_in) begin : cmp
    logic [N-1:0] e_oh, e_oth, e_ack, e_ws;
    logic [3:0]   e_ctl;
    logic [127:0] e_desc, e_data;
    if (m_valid) begin
      e_oh   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_oth  = (m_owner >= 0) ? ~(N'(1) << m_gid) : '0;
      e_ack  = tx_ack ? e_oh : '0;
      e_ws   = ~e_oh | (tx_ws ? e_oh : '0);
      e_ctl  = (m_owner >= 0) ? {bitof(req_tx_req, m_owner), bitof(req_tx_dfr, m_owner),
                                 bitof(req_tx_dv, m_owner), bitof(req_tx_err, m_owner)} : 4'h0;
      e_desc = (m_owner >= 0) ? slot(req_tx_desc, m_owner) : '0;
      e_data = (m_owner >= 0) ? slot(req_tx_data, m_owner) : '0;
      chk("m_req_sel", 128'(req_sel), 128'(e_oh));
      chk("m_ready_others", 128'(req_ready_others), 128'(e_oth));
      chk("m_grant_id", 128'(grant_id), 128'(3'(m_gid)));
      chk("m_timeout_err", 128'(timeout_err), 128'(m_terr));
      chk("m_tx_ctl", 128'({tx_req, tx_dfr, tx_dv, tx_err}), 128'(e_ctl));
      chk("m_tx_desc", tx_desc, e_desc);
      chk("m_tx_data", tx_data, e_data);
      chk("m_tx_ack", 128'(req_tx_ack), 128'(e_ack));
      chk("m_tx_ws", 128'(req_tx_ws), 128'(e_ws));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    int n, id, idle;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    // Reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_sel", 128'(req_sel), 128'(4'b0000));
    chk("rst_gid", 128'(grant_id), 128'(3'd0));
    chk("rst_terr", 128'(timeout_err), 128'(1'b0));
    chk("rst_ctl", 128'({tx_req, tx_dfr, tx_dv}), 128'(3'b000));

    // Single requester
    reset = 1'b0; req_ready = 4'b0100;
    tick();
    chk("single_sel", 128'(req_sel), 128'(4'b0100));
    chk("single_gid", 128'(grant_id), 128'(3'd2));
    req_ready = '0; req_busy = 4'b0100;
    req_tx_desc = rand_wide(); req_tx_data = rand_wide();
    tick();
    chk("single_others", 128'(req_ready_others), 128'(4'b1011));
    chk("single_desc", tx_desc, slot(req_tx_desc, 2));
    chk("single_data", tx_data, slot(req_tx_data, 2));
    tick(); tick();
    req_busy = '0;
    tick();
    chk("single_drain_sel", 128'(req_sel), 128'(4'b0100));
    tick();
    chk("single_idle_sel", 128'(req_sel), 128'(4'b0000));

    // Round-robin from reset with all requesters ready
    reset = 1'b1; req_ready = 4'b1111;
    tick();
    reset = 1'b0;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (req_sel == '0 && n < 10) begin tick(); n++; end
      id = idx_of(req_sel);
      chk("rr_order", 128'(id), 128'(exp_order[g]));
      if (g == 4) req_ready = '0;
      req_busy = (id >= 0) ? (N'(1) << id) : '0;
      tick(); tick();
      req_busy = '0;
      n = 0;
      while (req_sel != '0 && n < 10) begin tick(); n++; end
      idle = 0;
      while (req_sel == '0 && idle < 10) begin tick(); idle++; end
      if (g < 4) chk("rr_idle_gap", 128'(idle), 128'(1));
    end

    // Timeout: requester 1 never raises busy
    req_ready = 4'b0010;
    tick();
    chk("to_grant", 128'(req_sel), 128'(4'b0010));
    req_ready = 4'b0110;
    n = 0;
    while (req_sel == 4'b0010 && n < 200) begin tick(); n++; end
    chk("to_cycles", 128'(n), 128'(64));
    chk("to_err", 128'(timeout_err), 128'(1'b1));
    tick();
    chk("to_next", 128'(req_sel), 128'(4'b0100));
    req_ready = '0; req_busy = 4'b0100;
    tick();
    req_busy = '0;
    tick(); tick();
    chk("to_sticky_sel", 128'(req_sel), 128'(4'b0000));
    chk("to_sticky_err", 128'(timeout_err), 128'(1'b1));

    // Backpressure isolation with requester 0 active
    req_ready = 4'b0001;
    tick();
    chk("bp_grant", 128'(req_sel), 128'(4'b0001));
    req_ready = '0; req_busy = 4'b0001;
    req_tx_req = 4'b1110; req_tx_dfr = 4'b1110; req_tx_dv = 4'b1111; req_tx_err = 4'b1110;
    req_tx_desc = rand_wide(); req_tx_data = rand_wide();
    tx_ws = 1'b1; tx_ack = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_ws", 128'(req_tx_ws), 128'(4'b1111));
      chk("bp_ack", 128'(req_tx_ack), 128'(4'b0001));
      chk("bp_ctl", 128'({tx_req, tx_dfr, tx_dv, tx_err}), 128'(4'b0010));
      chk("bp_desc", tx_desc, slot(req_tx_desc, 0));
      tick();
    end
    tx_ws = 1'b0; tx_ack = 1'b0;
    tick();
    chk("bp_ws_release", 128'(req_tx_ws), 128'(4'b1110));
    chk("bp_ack_release", 128'(req_tx_ack), 128'(4'b0000));

    // Drain: busy drops while the winner still drives dv
    req_busy = '0; req_ready = 4'b0010;
    tick();
    chk("drain_sel_a", 128'(req_sel), 128'(4'b0001));
    tick();
    chk("drain_sel_b", 128'(req_sel), 128'(4'b0001));
    req_tx_dv = 4'b1110;
    tick();
    chk("drain_idle", 128'(req_sel), 128'(4'b0000));
    tick();
    chk("drain_next", 128'(req_sel), 128'(4'b0010));

    // Reset while requester 1 is active
    req_ready = '0; req_busy = 4'b0010;
    tick();
    chk("ract_ctl", 128'({tx_req, tx_dfr, tx_dv}), 128'(3'b111));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ract_sel", 128'(req_sel), 128'(4'b0000));
    chk("ract_ctl0", 128'({tx_req, tx_dfr, tx_dv}), 128'(3'b000));
    chk("ract_terr", 128'(timeout_err), 128'(1'b0));
    req_ready = 4'b1111; req_busy = '0;
    tick();
    chk("ract_prio", 128'(req_sel), 128'(4'b0001));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 599) == 0);
      req_ready   = N'($urandom);
      req_busy    = N'($urandom) | N'($urandom);
      req_tx_req  = N'($urandom);
      req_tx_dfr  = N'($urandom);
      req_tx_dv   = N'($urandom);
      req_tx_err  = N'($urandom);
      req_tx_desc = rand_wide();
      req_tx_data = rand_wide();
      tx_ack      = 1'($urandom);
      tx_ws       = 1'($urandom);
      tick();
    end
    reset = 1'b0; req_ready = '0; req_busy = '0;
    req_tx_req = '0; req_tx_dfr = '0; req_tx_dv = '0; req_tx_err = '0;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
